cpu_control_unit: RTL and testbench

//  Fetch/decode/execute sequencer for the 16-bit accumulator CPU. Owns PC, IR and AC. Drives the

---
 rtl/cpu_control_unit.sv | 193 +++++++++++++++++++
 tb/tb_cpu_control_unit.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_unit.sv
// cpu_control_unit
//   Fetch/decode/execute sequencer for the 16-bit accumulator CPU. Owns the
//   architectural registers PC, IR and AC. Drives a synchronous-read memory
//   (read data valid one cycle after the address) and feeds an external
//   combinational ALU with its opcode and operands.
//
// Parameters
//   RESET_PC         PC value loaded on reset
//   HALT_ON_ILLEGAL  1: reserved opcode halts and sets illegal; 0: treated as NOP
//
// Ports
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   run                   start request, sampled only in IDLE
//   mem_addr/wdata/we     memory address, write data (= ac), write strobe
//   mem_rdata             registered memory read data
//   alu_op/alu_a/alu_b    ALU opcode (ir[14:11]), operand1 (ac), operand2 (mem_rdata)
//   alu_result            ALU result
//   pc, ir, ac            architectural registers
//   busy, halted          status: executing / parked in HALT
//   illegal               sticky reserved-opcode flag
//   retired               (only with CU_RETIRE_COUNT_EN) retired-instruction count
//
// Build option: define CU_RETIRE_COUNT_EN to add the 32-bit retired counter.
//
// state   | meaning
// IDLE    | waiting for run; mem_addr = pc
// FETCH   | pc presented to memory; pc increments
// LOAD_IR | instruction word captured into ir
// DECODE  | control ops execute; store strobe; operand address presented
// OPERAND | ac takes loaded data or ALU result
// HALT    | terminal until reset

module cpu_control_unit #(
  parameter logic [15:0] RESET_PC        = 16'h0000,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output logic [3:0]  alu_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_result,
  output logic [15:0] pc,
  output logic [15:0] ir,
  output logic [15:0] ac,
  output logic        busy,
  output logic        halted,
  output logic        illegal
`ifdef CU_RETIRE_COUNT_EN
  ,
  output logic [31:0] retired
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD_IR,
    S_DECODE,
    S_OPERAND,
    S_HALT
  } state_t;

  localparam logic [2:0] OP_HALT  = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;
  localparam logic [2:0] OP_JUMP  = 3'd3;
  localparam logic [2:0] OP_JUMPZ = 3'd4;
  localparam logic [2:0] OP_LOADI = 3'd5;
  localparam logic [2:0] OP_NOP   = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;
  localparam logic [3:0] ALU_DIV  = 4'b0011;

  state_t      state, state_nxt;
  logic [15:0] pc_nxt, ir_nxt, ac_nxt;
  logic        illegal_nxt;

  logic        is_alu;
  logic [2:0]  ctl_op;
  logic [15:0] a12_addr;
  logic [15:0] alu_addr;

  assign is_alu   = ir[15];
  assign ctl_op   = ir[14:12];
  assign a12_addr = {4'b0, ir[11:0]};
  assign alu_addr = {5'b0, ir[10:0]};

  assign alu_op    = ir[14:11];
  assign alu_a     = ac;
  assign alu_b     = mem_rdata;
  assign mem_wdata = ac;
  assign busy      = (state != S_IDLE) && (state != S_HALT);
  assign halted    = (state == S_HALT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      ir      <= '0;
      ac      <= '0;
      illegal <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      ir      <= ir_nxt;
      ac      <= ac_nxt;
      illegal <= illegal_nxt;
    end
  end

  // mem_we is decoded from state, so an asynchronous reset during a store
  // decode removes the strobe before the write edge.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    ir_nxt      = ir;
    ac_nxt      = ac;
    illegal_nxt = illegal;
    mem_addr    = pc;
    mem_we      = 1'b0;
    case (state)
      S_IDLE: begin
        if (run) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        pc_nxt    = pc + 16'd1;
        state_nxt = S_LOAD_IR;
      end
      S_LOAD_IR: begin
        ir_nxt    = mem_rdata;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (is_alu) begin
          mem_addr  = alu_addr;
          state_nxt = S_OPERAND;
        end else begin
          state_nxt = S_FETCH;
          case (ctl_op)
            OP_HALT:  state_nxt = S_HALT;
            OP_LOAD: begin
              mem_addr  = a12_addr;
              state_nxt = S_OPERAND;
            end
            OP_STORE: begin
              mem_addr = a12_addr;
              mem_we   = 1'b1;
            end
            OP_JUMP:  pc_nxt = a12_addr;
            OP_JUMPZ: if (ac == 16'h0000) pc_nxt = a12_addr;
            OP_LOADI: ac_nxt = a12_addr;
            OP_NOP:   ;
            default: begin
              if (HALT_ON_ILLEGAL) begin
                illegal_nxt = 1'b1;
                state_nxt   = S_HALT;
              end
            end
          endcase
        end
      end
      S_OPERAND: begin
        state_nxt = S_FETCH;
        if (!is_alu)
          ac_nxt = mem_rdata;
        else if (alu_op == ALU_DIV && mem_rdata == 16'h0000)
          ac_nxt = 16'hFFFF;   // divide guard: ALU output is not trusted here
        else
          ac_nxt = alu_result;
      end
      S_HALT: ;
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef CU_RETIRE_COUNT_EN
  // Reserved opcodes never retire, even when they fall through as a NOP.
  logic retire;
  assign retire = (state_nxt == S_FETCH) &&
                  ((state == S_OPERAND) || (state == S_DECODE && ctl_op != OP_RSVD));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       retired <= '0;
    else if (retire) retired <= retired + 32'd1;
  end
`endif

endmodule

// File: tb/tb_cpu_control_unit.sv
// Testbench for cpu_control_unit. Instruction-level reference model predicts
// stores and final architectural state; a monitor compares them as the DUT
// strobes mem_we or enters HALT. A second instance covers RESET_PC=FFFF and
// HALT_ON_ILLEGAL=0.

module tb_cpu_control_unit;

  logic        clk = 1'b0;
  logic        reset, run, run1, load;
  logic [15:0] mem_addr, mem_wdata, alu_a, alu_b, alu_result, pc, ir, ac;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_we, busy, halted, illegal;
  logic [3:0]  alu_op;
  logic [15:0] mem_addr1, mem_wdata1, alu_a1, alu_b1, alu_result1, pc1, ir1, ac1;
  logic [15:0] mem_rdata1 = 16'h0000;
  logic        mem_we1, busy1, halted1, illegal1;
  logic [3:0]  alu_op1;
`ifdef CU_RETIRE_COUNT_EN
  logic [31:0] retired, retired1;
`endif

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a * b;
      4'd3:  return (b == 16'h0000) ? 16'hDEAD : a / b;
      4'd4:  return a & b;
      4'd5:  return a | b;
      4'd6:  return a ^ b;
      4'd7:  return ~a;
      4'd8:  return a << 1;
      4'd9:  return a >> 1;
      4'd10: return b;
      4'd11: return a + 16'd1;
      default: return a ^ {b[7:0], b[15:8]};
    endcase
  endfunction

  assign alu_result  = alu_f(alu_op, alu_a, alu_b);
  assign alu_result1 = alu_f(alu_op1, alu_a1, alu_b1);

  cpu_control_unit dut (
    .clk(clk), .reset(reset), .run(run),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .pc(pc), .ir(ir), .ac(ac), .busy(busy), .halted(halted), .illegal(illegal)
`ifdef CU_RETIRE_COUNT_EN
    , .retired(retired)
`endif
  );

  cpu_control_unit #(.RESET_PC(16'hFFFF), .HALT_ON_ILLEGAL(1'b0)) dut1 (
    .clk(clk), .reset(reset), .run(run1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_we(mem_we1), .mem_rdata(mem_rdata1),
    .alu_op(alu_op1), .alu_a(alu_a1), .alu_b(alu_b1), .alu_result(alu_result1),
    .pc(pc1), .ir(ir1), .ac(ac1), .busy(busy1), .halted(halted1), .illegal(illegal1)
`ifdef CU_RETIRE_COUNT_EN
    , .retired(retired1)
`endif
  );

  logic [15:0] mem     [0:65535];
  logic [15:0] mem1    [0:65535];
  logic [15:0] img     [0:65535];
  logic [15:0] img1    [0:65535];
  logic [15:0] ref_mem [0:65535];

  always @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < 65536; k++) begin
        mem[k]  <= img[k];
        mem1[k] <= img1[k];
      end
    end else begin
      mem_rdata  <= mem[mem_addr];
      mem_rdata1 <= mem1[mem_addr1];
      if (mem_we)  mem[mem_addr]   <= mem_wdata;
      if (mem_we1) mem1[mem_addr1] <= mem_wdata1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] ac;
    logic        ill;
    int          cyc;
    logic [31:0] ret;
  } fin_t;
  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } st_t;

  fin_t fin_q[$];
  st_t  st_q[$];
  int   checks = 0, failures = 0;
  int   start_cyc = 0, last_cycles = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Instruction-level model of the program in img, starting at pc=0.
  function automatic void model_run();
    logic [15:0] p, a, w, b;
    logic        il, done;
    int          cy;
    logic [31:0] rt;
    fin_t        f;
    st_t         s;
    for (int k = 0; k < 65536; k++) ref_mem[k] = img[k];
    p = 16'h0000; a = 16'h0000; il = 1'b0; done = 1'b0; cy = 0; rt = 32'd0;
    for (int n = 0; n < 1000 && !done; n++) begin
      w = ref_mem[p];
      p = p + 16'd1;
      cy += 3;
      if (w[15]) begin
        b = ref_mem[{5'b0, w[10:0]}];
        a = (w[14:11] == 4'd3 && b == 16'h0000) ? 16'hFFFF : alu_f(w[14:11], a, b);
        cy += 1; rt++;
      end else begin
        case (w[14:12])
          3'd0: done = 1'b1;
          3'd1: begin a = ref_mem[{4'b0, w[11:0]}]; cy += 1; rt++; end
          3'd2: begin
            ref_mem[{4'b0, w[11:0]}] = a;
            s.addr = {4'b0, w[11:0]}; s.data = a; st_q.push_back(s); rt++;
          end
          3'd3: begin p = {4'b0, w[11:0]}; rt++; end
          3'd4: begin if (a == 16'h0000) p = {4'b0, w[11:0]}; rt++; end
          3'd5: begin a = {4'b0, w[11:0]}; rt++; end
          3'd6: rt++;
          default: begin il = 1'b1; done = 1'b1; end
        endcase
      end
    end
    f.pc = p; f.ac = a; f.ill = il; f.cyc = cy; f.ret = rt;
    fin_q.push_back(f);
  endfunction

  initial begin : monitor
    logic prev_halted;
    bit   x_seen;
    st_t  s;
    fin_t f;
    prev_halted = 1'b0;
    x_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_halted = 1'b0;
        x_seen = 1'b0;
      end else begin
        if ($isunknown({mem_addr, mem_wdata, mem_we, alu_op, alu_b, pc, ir, ac,
                        busy, halted, illegal}))
          x_seen = 1'b1;
        if (mem_we === 1'b1) begin
          chk("store_expected", 32'(st_q.size() != 0), 32'h1);
          if (st_q.size() != 0) begin
            s = st_q.pop_front();
            chk("store_addr", 32'(mem_addr), 32'(s.addr));
            chk("store_data", 32'(mem_wdata), 32'(s.data));
          end
        end
        if (halted === 1'b1 && !prev_halted) begin
          last_cycles = cyc - start_cyc;
          if (fin_q.size() != 0) begin
            f = fin_q.pop_front();
            chk("final_pc", 32'(pc), 32'(f.pc));
            chk("final_ac", 32'(ac), 32'(f.ac));
            chk("final_illegal", 32'(illegal), 32'(f.ill));
            chk("final_cycles", 32'(last_cycles), 32'(f.cyc));
            chk("no_x_outputs", 32'(x_seen), 32'h0);
            chk("stores_drained", 32'(st_q.size()), 32'h0);
`ifdef CU_RETIRE_COUNT_EN
            chk("final_retired", retired, f.ret);
`endif
          end
        end
        prev_halted = halted;
      end
    end
  end

  task automatic clear_img();
    for (int k = 0; k < 65536; k++) img[k] = 16'h0000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    load  = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic run_prog();
    model_run();
    @(negedge clk); run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    start_cyc = cyc;
    chk("busy_after_run", 32'(busy), 32'h1);
    for (int i = 0; i < 2000 && halted !== 1'b1; i++) @(negedge clk);
    if (halted !== 1'b1) begin
      chk("halt_timeout", 32'(halted), 32'h1);
      fin_q.delete();
      st_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic img_test1();
    clear_img();
    img[16'h0000] = 16'h1010; img[16'h0001] = 16'h8011;
    img[16'h0002] = 16'h2012; img[16'h0003] = 16'h0000;
    img[16'h0010] = 16'h0005; img[16'h0011] = 16'h0007;
  endtask

  task automatic gen_random();
    int          len, k, t;
    logic [15:0] w;
    clear_img();
    len = int'($urandom_range(4, 12));
    for (int i = 0; i < len; i++) begin
      k = int'($urandom_range(0, 9));
      t = int'($urandom_range(i + 1, len));
      case (k)
        0: w = {4'h1, 8'h10, 4'($urandom_range(0, 15))};
        1: w = {4'h2, 8'h10, 4'($urandom_range(0, 15))};
        2, 3: w = {1'b1, 4'($urandom_range(0, 15)), 7'h10, 4'($urandom_range(0, 15))};
        4: w = {4'h3, 12'(t)};
        5: w = {4'h4, 12'(t)};
        6: w = {4'h5, 12'($urandom)};
        7: w = 16'h6000;
        8: w = 16'h5000;
        default: w = ($urandom_range(0, 3) == 0) ? {4'h7, 12'($urandom)} : 16'hB105;
      endcase
      img[16'(i)] = w;
    end
    for (int r = 0; r < 16; r++)
      img[16'h0100 + 16'(r)] = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    reset = 1'b1; run = 1'b0; run1 = 1'b0; load = 1'b0;
    clear_img();
    for (int k = 0; k < 65536; k++) img1[k] = 16'h0000;
    img1[16'hFFFF] = 16'h6000;
    img1[16'h0000] = 16'h7000;
    img1[16'h0001] = 16'h5003;
    img1[16'h0002] = 16'h0000;
    do_reset();

    chk("reset_pc", 32'(pc), 32'h0);
    chk("reset_ir", 32'(ir), 32'h0);
    chk("reset_ac", 32'(ac), 32'h0);
    chk("reset_illegal", 32'(illegal), 32'h0);
    chk("reset_we", 32'(mem_we), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_halted", 32'(halted), 32'h0);
    chk("reset_pc1", 32'(pc1), 32'hFFFF);

    // PC wrap and reserved-as-NOP on the second instance
    @(negedge clk); run1 = 1'b1;
    @(posedge clk); #1; run1 = 1'b0;
    @(posedge clk); #1;
    chk("t6_pc_wrap", 32'(pc1), 32'h0000);
    @(posedge clk); #1;
    @(posedge clk); #1;
`ifdef CU_RETIRE_COUNT_EN
    chk("t6_retired_after_nop", retired1, 32'h1);
`endif
    for (int i = 0; i < 200 && halted1 !== 1'b1; i++) @(negedge clk);
    chk("t4b_halted1", 32'(halted1), 32'h1);
    chk("t4b_pc1", 32'(pc1), 32'h0003);
    chk("t4b_ac1", 32'(ac1), 32'h0003);
    chk("t4b_illegal1", 32'(illegal1), 32'h0);

    // add/store
    img_test1(); do_reset(); run_prog();
    chk("t1_mem12", 32'(mem[16'h0012]), 32'h000C);
    chk("t1_ac", 32'(ac), 32'h000C);
    chk("t1_pc", 32'(pc), 32'h0004);
    chk("t1_cycles", 32'(last_cycles), 32'd14);
    run = 1'b1;
    repeat (3) @(posedge clk);
    #1 run = 1'b0;
    chk("t1_halt_sticky", 32'(halted), 32'h1);
    chk("t1_halt_pc", 32'(pc), 32'h0004);
    chk("t1_halt_busy", 32'(busy), 32'h0);

    // JUMPZ taken / not taken
    clear_img(); img[0] = 16'h5000; img[1] = 16'h4020;
    do_reset(); run_prog();
    chk("t2_taken_pc", 32'(pc), 32'h0021);
    chk("t2_taken_halted", 32'(halted), 32'h1);
    clear_img(); img[0] = 16'h5001; img[1] = 16'h4020;
    do_reset(); run_prog();
    chk("t2_not_taken_pc", 32'(pc), 32'h0003);

    // divide by zero
    clear_img(); img[0] = 16'h5009; img[1] = 16'h9830;
    do_reset(); run_prog();
    chk("t3_div0_ac", 32'(ac), 32'hFFFF);

    // illegal opcode halts
    clear_img(); img[0] = 16'h7000;
    do_reset(); run_prog();
    chk("t4_illegal", 32'(illegal), 32'h1);
    chk("t4_halted", 32'(halted), 32'h1);
    chk("t4_cycles", 32'(last_cycles), 32'd3);

    // reset during the store decode
    img_test1(); do_reset();
    @(negedge clk); run = 1'b1;
    @(posedge clk); #1; run = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("t5_we_in_decode", 32'(mem_we), 32'h1);
    chk("t5_addr_in_decode", 32'(mem_addr), 32'h0012);
    #1 reset = 1'b1;
    #1;
    chk("t5_we_async_drop", 32'(mem_we), 32'h0);
    chk("t5_pc_reset", 32'(pc), 32'h0000);
    chk("t5_ac_reset", 32'(ac), 32'h0000);
    chk("t5_idle", 32'({busy, halted}), 32'h0);
    @(posedge clk); #1;
    chk("t5_mem_unchanged", 32'(mem[16'h0012]), 32'h0000);
    reset = 1'b0;

    for (int n = 0; n < 25; n++) begin
      gen_random();
      do_reset();
      run_prog();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
